// File: rtl/pow_5_pkg.sv
// Shared constants, state encoding and sizing helper for the x^5 stream front end.
package pow_5_pkg;

  // Operand/result width of the iterative x^5 engine.
  localparam int WIDTH_DEF = 18;

  // Front-end sequencer states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Ceiling log2, used to size pointers, counters and the watchdog.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pow_5_fifo.sv
// Synchronous operand FIFO: wrap-around pointers carrying one extra bit so
// that full and empty are distinguished, plus a registered occupancy count.
module pow_5_fifo
  import pow_5_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE = CW'(32'd1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    wr_ptr_q;
  logic [CW-1:0]    wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q;
  logic [CW-1:0]    rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Equal pointers mean empty; same index with opposite wrap bit means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state: guarded push/pop, pointer advance and occupancy update.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointer and count registers; reset flushes the queue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pow_5_stream_front_end.sv
// Stream front end for the run/ready x^5 engine: buffers operands, issues one
// run pulse per operand, captures the result on the ready strobe and presents
// it on a valid/ready output. A watchdog drops the item if the engine is silent.
module pow_5_stream_front_end
  import pow_5_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_n,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_n_pow_5,
  output logic [WIDTH-1:0]      out_n,
  output logic                  eng_run,
  output logic [WIDTH-1:0]      eng_n,
  input  logic                  eng_ready,
  input  logic [WIDTH-1:0]      eng_n_pow_5,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [clog2(DEPTH):0] fifo_count
);

  localparam int WDW = clog2(TIMEOUT + 1);
  // The watchdog expires on the TIMEOUT-th WAIT cycle (count starts at 0).
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(32'd1);

  state_e           state_q;
  state_e           state_d;
  logic [WDW-1:0]   wd_q;
  logic [WDW-1:0]   wd_d;
  logic [WIDTH-1:0] eng_n_q;
  logic [WIDTH-1:0] eng_n_d;
  logic             eng_run_q;
  logic             eng_run_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_n_q;
  logic [WIDTH-1:0] out_n_d;
  logic [WIDTH-1:0] out_pow_q;
  logic [WIDTH-1:0] out_pow_d;
  logic             busy_q;
  logic             busy_d;
  logic             timeout_err_q;
  logic             timeout_err_d;

  logic             issue_s;
  logic             capture_s;
  logic             expire_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [WIDTH-1:0] fifo_head_s;
  logic             push_s;

  // in_ready comes from the registered occupancy only: no bypass when full.
  assign in_ready = !fifo_full_s;
  assign push_s   = in_valid && !fifo_full_s;

  pow_5_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (issue_s),
    .wdata   (in_n),
    .rdata   (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count)
  );

  // Sequencer next state: issue only when the output slot is free or being
  // drained, so a capture can never overwrite an unconsumed result.
  always_comb begin
    state_d   = state_q;
    issue_s   = 1'b0;
    capture_s = 1'b0;
    expire_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s && (!out_valid_q || out_ready)) begin
          issue_s = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A capture on the expiry cycle takes priority over the timeout.
        if (eng_ready) begin
          capture_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (wd_q == WD_LAST) begin
          expire_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs: run pulse, engine operand, watchdog, result slot, flags.
  always_comb begin
    wd_d          = wd_q;
    eng_n_d       = eng_n_q;
    eng_run_d     = issue_s;
    out_valid_d   = out_valid_q;
    out_n_d       = out_n_q;
    out_pow_d     = out_pow_q;
    busy_d        = (state_d == ST_WAIT);
    timeout_err_d = timeout_err_q || expire_s;
    if (issue_s) begin
      eng_n_d = fifo_head_s;
      wd_d    = '0;
    end else if (state_q == ST_WAIT) begin
      wd_d = wd_q + WD_ONE;
    end else begin
      wd_d = wd_q;
    end
    if (capture_s) begin
      out_valid_d = 1'b1;
      out_n_d     = eng_n_q;
      out_pow_d   = eng_n_pow_5;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State register and output flops; reset abandons any in-flight item.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wd_q          <= '0;
      eng_n_q       <= '0;
      eng_run_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_n_q       <= '0;
      out_pow_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      eng_n_q       <= eng_n_d;
      eng_run_q     <= eng_run_d;
      out_valid_q   <= out_valid_d;
      out_n_q       <= out_n_d;
      out_pow_q     <= out_pow_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign eng_run     = eng_run_q;
  assign eng_n       = eng_n_q;
  assign out_valid   = out_valid_q;
  assign out_n       = out_n_q;
  assign out_n_pow_5 = out_pow_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pow_5_stream_front_end.sv
// Scoreboard bench for pow_5_stream_front_end with a behavioural x^5 engine.
module tb_pow_5_stream_front_end;

  localparam int WIDTH = 18;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 15;
  localparam int CW = 3;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_n = '0;
  logic             out_ready = 1'b1;
  logic             eng_ready = 1'b0;
  logic [WIDTH-1:0] eng_n_pow_5 = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_n_pow_5;
  logic [WIDTH-1:0] out_n;
  logic             eng_run;
  logic [WIDTH-1:0] eng_n;
  logic             busy;
  logic             timeout_err;
  logic [CW-1:0]    fifo_count;

  pow_5_stream_front_end #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_n        (in_n),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_n_pow_5 (out_n_pow_5),
    .out_n       (out_n),
    .eng_run     (eng_run),
    .eng_n       (eng_n),
    .eng_ready   (eng_ready),
    .eng_n_pow_5 (eng_n_pow_5),
    .busy        (busy),
    .timeout_err (timeout_err),
    .fifo_count  (fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Engine model controls.
  int   eng_lat = 5;
  bit   eng_respond = 1'b1;
  bit   spur_req = 1'b0;
  int   eng_cnt = 0;
  logic [WIDTH-1:0] eng_hold = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] pow5(input logic [WIDTH-1:0] x);
    logic [89:0] acc;
    acc = {72'd0, x};
    acc = acc * acc * acc * acc * acc;
    return acc[WIDTH-1:0];
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Engine stand-in: ready strobe eng_lat cycles after the run cycle.
  initial forever begin
    @(negedge clock);
    eng_ready = 1'b0;
    eng_n_pow_5 = '1;
    if (!reset_n) begin
      eng_cnt = 0;
    end else if (eng_run) begin
      chk("run_while_engine_busy", eng_cnt, 32'd0);
      eng_hold = eng_n;
      eng_cnt = eng_lat;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && eng_respond) begin
        eng_ready = 1'b1;
        eng_n_pow_5 = pow5(eng_hold);
      end
    end else if (spur_req) begin
      spur_req = 1'b0;
      eng_ready = 1'b1;
      eng_n_pow_5 = 18'd777;
    end
  end

  // Output monitor: every presented result must match the scoreboard head.
  initial forever begin
    @(negedge clock);
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("out_n", {14'd0, out_n}, {14'd0, exp_q[0].opnd});
        chk("out_n_pow_5", {14'd0, out_n_pow_5}, {14'd0, exp_q[0].res});
        if (out_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] n, input bit expect_out,
                      input logic [WIDTH-1:0] exp_p, output int hs_cyc);
    exp_t e;
    hs_cyc = -1;
    in_valid = 1'b1;
    in_n = n;
    for (int k = 0; k < 100 && hs_cyc < 0; k++) begin
      @(negedge clock);
      if (in_ready) begin
        hs_cyc = cyc;
        if (expect_out) begin
          e.opnd = n;
          e.res = exp_p;
          exp_q.push_back(e);
        end
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (hs_cyc < 0) chk("push_accepted", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clock);
      done = (exp_q.size() == 0) && !busy && !out_valid && (fifo_count == '0);
      @(posedge clock);
      #1;
    end
    chk("drain_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int t0, hs, trun, tval, tto;
    bit busy_at;

    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_eng_run", {31'd0, eng_run}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_out_n", {14'd0, out_n}, 32'd0);
    chk("rst_out_pow", {14'd0, out_n_pow_5}, 32'd0);
    chk("rst_eng_n", {14'd0, eng_n}, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end

    // Single operand latency: run at +2, result valid at +8.
    push(18'd3, 1'b1, 18'd243, t0);
    trun = -100;
    tval = -100;
    for (int k = 0; k < 20 && tval < 0; k++) begin
      @(negedge clock);
      if (eng_run && trun < 0) trun = cyc;
      if (out_valid && tval < 0) tval = cyc;
      @(posedge clock);
      #1;
    end
    chk("run_latency", trun - t0, 32'd2);
    chk("valid_latency", tval - t0, 32'd8);
    wait_drain(50);
    chk("count_after_single", {29'd0, fifo_count}, 32'd0);

    // Back-to-back burst fills the FIFO; results come out in order.
    push(18'd10, 1'b1, 18'd100000, hs);
    push(18'd20, 1'b1, 18'd54272, hs);
    push(18'd2, 1'b1, 18'd32, hs);
    push(18'd1, 1'b1, 18'd1, hs);
    push(18'd7, 1'b1, 18'd16807, hs);
    @(negedge clock);
    chk("burst_count_full", {29'd0, fifo_count}, 32'd4);
    chk("burst_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    wait_drain(200);

    // Back-pressure: result held, no further issue until out_ready returns.
    out_ready = 1'b0;
    push(18'd3, 1'b1, 18'd243, hs);
    push(18'd4, 1'b1, 18'd1024, hs);
    for (int k = 0; k < 30 && !out_valid; k++) begin
      @(negedge clock);
      if (!out_valid) begin
        @(posedge clock);
        #1;
      end
    end
    chk("hold_valid_seen", {31'd0, out_valid}, 32'd1);
    @(posedge clock);
    #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_no_run", {31'd0, eng_run}, 32'd0);
      chk("hold_not_busy", {31'd0, busy}, 32'd0);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("release_run_not_yet", {31'd0, eng_run}, 32'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("release_run_next_cycle", {31'd0, eng_run}, 32'd1);
    @(posedge clock);
    #1;
    wait_drain(50);

    // Silent engine: watchdog fires after TIMEOUT WAIT cycles, item dropped.
    eng_respond = 1'b0;
    push(18'd9, 1'b0, 18'd0, hs);
    trun = -100;
    tto = -200;
    busy_at = 1'b1;
    for (int k = 0; k < 40 && tto < 0; k++) begin
      @(negedge clock);
      if (eng_run && trun < 0) trun = cyc;
      if (timeout_err && tto < 0) begin
        tto = cyc;
        busy_at = busy;
      end
      @(posedge clock);
      #1;
    end
    chk("timeout_wait_cycles", tto - trun, 32'd15);
    chk("timeout_back_to_idle", {31'd0, busy_at}, 32'd0);
    eng_respond = 1'b1;
    push(18'd2, 1'b1, 18'd32, hs);
    wait_drain(50);
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Asynchronous reset while WAIT with three operands buffered.
    push(18'd11, 1'b0, 18'd0, hs);
    push(18'd12, 1'b0, 18'd0, hs);
    push(18'd13, 1'b0, 18'd0, hs);
    push(18'd14, 1'b0, 18'd0, hs);
    @(negedge clock);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    chk("pre_reset_count", {29'd0, fifo_count}, 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_eng_run", {31'd0, eng_run}, 32'd0);
    chk("async_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    push(18'd4, 1'b1, 18'd1024, hs);
    wait_drain(50);

    // Ready on exactly the expiry cycle is captured, no timeout raised.
    eng_lat = 14;
    push(18'd5, 1'b1, 18'd3125, hs);
    wait_drain(60);
    chk("late_ready_no_timeout", {31'd0, timeout_err}, 32'd0);
    eng_lat = 5;

    // Spurious ready in IDLE produces nothing.
    spur_req = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("spurious_no_output", {31'd0, out_valid}, 32'd0);
      chk("spurious_not_busy", {31'd0, busy}, 32'd0);
      @(posedge clock);
      #1;
    end
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
